// File: rtl/imm_decode_stage_if.sv
// Handshake and decoded-record bus of the immediate-decode stage.
// master = upstream/downstream environment, slave = the decode stage.
interface imm_decode_stage_if;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_imm32;
  logic [4:0]  out_rs;
  logic [4:0]  out_rt;
  logic [4:0]  out_dst;
  logic        out_reg_write;
  logic [2:0]  out_ext_kind;
  logic        out_illegal;

  modport master (
    output flush, in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_imm32, out_rs, out_rt, out_dst,
           out_reg_write, out_ext_kind, out_illegal
  );

  modport slave (
    input  flush, in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_imm32, out_rs, out_rt, out_dst,
           out_reg_write, out_ext_kind, out_illegal
  );
endinterface

// File: rtl/imm_decode_stage.sv
// MIPS immediate-decode stage: combinational decode of the incoming
// instruction into a record, held in a main output register backed by a
// one-entry skid register so upstream sees a registered ready.
module imm_decode_stage (
  input logic             clk,
  input logic             reset,
  imm_decode_stage_if.slave bus
);

  localparam logic [2:0] KIND_NONE   = 3'd0;
  localparam logic [2:0] KIND_SIGN   = 3'd1;
  localparam logic [2:0] KIND_ZERO   = 3'd2;
  localparam logic [2:0] KIND_LUI    = 3'd3;
  localparam logic [2:0] KIND_BRANCH = 3'd4;

  typedef struct packed {
    logic [31:0] imm32;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dst;
    logic        reg_write;
    logic [2:0]  ext_kind;
    logic        illegal;
  } rec_t;

  function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

  function automatic logic [31:0] zero_ext16(input logic [15:0] imm);
    return {16'h0000, imm};
  endfunction

  function automatic logic [31:0] branch_ext16(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

  rec_t        dec_p0;
  rec_t        main_p1;
  rec_t        skid_p1;
  logic        vld_p1;
  logic        skid_vld_p1;
  logic        in_ready_p1;
  logic        vld_d;
  logic        skid_vld_d;
  logic        load_main_in;
  logic        load_main_skid;
  logic        load_skid;
  logic        accept;
  logic        consume;
  logic [5:0]  op;
  logic [15:0] imm;

  assign op      = bus.in_instr[31:26];
  assign imm     = bus.in_instr[15:0];
  assign accept  = bus.in_valid & in_ready_p1;
  assign consume = vld_p1 & bus.out_ready;

  // Stage p0: decode the raw instruction word into a record.
  always_comb begin
    dec_p0           = '0;
    dec_p0.rs        = bus.in_instr[25:21];
    dec_p0.rt        = bus.in_instr[20:16];
    case (op)
      6'h0F: begin
        dec_p0.imm32     = {imm, 16'h0000};
        dec_p0.ext_kind  = KIND_LUI;
        dec_p0.dst       = bus.in_instr[20:16];
        dec_p0.reg_write = 1'b1;
      end
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h23: begin
        dec_p0.imm32     = sign_ext16(imm);
        dec_p0.ext_kind  = KIND_SIGN;
        dec_p0.dst       = bus.in_instr[20:16];
        dec_p0.reg_write = 1'b1;
      end
      6'h0C, 6'h0D, 6'h0E: begin
        dec_p0.imm32     = zero_ext16(imm);
        dec_p0.ext_kind  = KIND_ZERO;
        dec_p0.dst       = bus.in_instr[20:16];
        dec_p0.reg_write = 1'b1;
      end
      6'h2B: begin
        dec_p0.imm32     = sign_ext16(imm);
        dec_p0.ext_kind  = KIND_SIGN;
      end
      6'h04, 6'h05: begin
        dec_p0.imm32     = branch_ext16(imm);
        dec_p0.ext_kind  = KIND_BRANCH;
      end
      6'h00: begin
        dec_p0.dst       = bus.in_instr[15:11];
        dec_p0.reg_write = 1'b1;
      end
      default: begin
        dec_p0.illegal   = 1'b1;
      end
    endcase
    // $zero is never a real write-back target.
    if (dec_p0.dst == 5'd0) dec_p0.reg_write = 1'b0;
  end

  // Next-state for the main/skid entries; flush overrides every move.
  always_comb begin
    vld_d          = vld_p1;
    skid_vld_d     = skid_vld_p1;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (bus.flush) begin
      vld_d      = 1'b0;
      skid_vld_d = 1'b0;
    end else if (consume) begin
      if (skid_vld_p1) begin
        load_main_skid = 1'b1;
        skid_vld_d     = 1'b0;
      end else if (accept) begin
        load_main_in   = 1'b1;
      end else begin
        vld_d          = 1'b0;
      end
    end else if (accept) begin
      if (!vld_p1) begin
        load_main_in   = 1'b1;
        vld_d          = 1'b1;
      end else begin
        load_skid      = 1'b1;
        skid_vld_d     = 1'b1;
      end
    end
  end

  // Stage p1 control: valid bits and the registered ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
      in_ready_p1 <= 1'b1;
    end else begin
      vld_p1      <= vld_d;
      skid_vld_p1 <= skid_vld_d;
      in_ready_p1 <= !skid_vld_d;
    end
  end

  // Stage p1 data: main and skid records, loaded only on a move.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_p1 <= '0;
      skid_p1 <= '0;
    end else begin
      if (load_main_skid)    main_p1 <= skid_p1;
      else if (load_main_in) main_p1 <= dec_p0;
      if (load_skid)         skid_p1 <= dec_p0;
    end
  end

  assign bus.in_ready      = in_ready_p1;
  assign bus.out_valid     = vld_p1;
  assign bus.out_imm32     = main_p1.imm32;
  assign bus.out_rs        = main_p1.rs;
  assign bus.out_rt        = main_p1.rt;
  assign bus.out_dst       = main_p1.dst;
  assign bus.out_reg_write = main_p1.reg_write;
  assign bus.out_ext_kind  = main_p1.ext_kind;
  assign bus.out_illegal   = main_p1.illegal;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed bench for imm_decode_stage: decode table, skid backpressure,
// flush and asynchronous reset.
module tb_imm_decode_stage;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  imm_decode_stage_if bus ();

  imm_decode_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm32;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dst;
    logic        rw;
    logic [2:0]  kind;
    logic        ill;
  } vec_t;

  vec_t vecs[11];

  task automatic check_rec(input string tag, input vec_t v);
    check_eq({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
    check_eq({tag, ".imm32"}, bus.out_imm32, v.imm32);
    check_eq({tag, ".rs"}, 32'(bus.out_rs), 32'(v.rs));
    check_eq({tag, ".rt"}, 32'(bus.out_rt), 32'(v.rt));
    check_eq({tag, ".dst"}, 32'(bus.out_dst), 32'(v.dst));
    check_eq({tag, ".rw"}, 32'(bus.out_reg_write), 32'(v.rw));
    check_eq({tag, ".kind"}, 32'(bus.out_ext_kind), 32'(v.kind));
    check_eq({tag, ".ill"}, 32'(bus.out_illegal), 32'(v.ill));
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, ".valid"}, 32'(bus.out_valid), 32'd0);
    check_eq({tag, ".imm32"}, bus.out_imm32, 32'd0);
    check_eq({tag, ".rs"}, 32'(bus.out_rs), 32'd0);
    check_eq({tag, ".rt"}, 32'(bus.out_rt), 32'd0);
    check_eq({tag, ".dst"}, 32'(bus.out_dst), 32'd0);
    check_eq({tag, ".rw"}, 32'(bus.out_reg_write), 32'd0);
    check_eq({tag, ".kind"}, 32'(bus.out_ext_kind), 32'd0);
    check_eq({tag, ".ill"}, 32'(bus.out_illegal), 32'd0);
    check_eq({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    //              instr          imm32          rs  rt  dst rw kind ill
    vecs[0]  = '{32'h3C01F0F0, 32'hF0F00000, 5'd0, 5'd1, 5'd1, 1'b1, 3'd3, 1'b0}; // LUI
    vecs[1]  = '{32'h3C00FFFF, 32'hFFFF0000, 5'd0, 5'd0, 5'd0, 1'b0, 3'd3, 1'b0}; // LUI to $0
    vecs[2]  = '{32'h2002FFFF, 32'hFFFFFFFF, 5'd0, 5'd2, 5'd2, 1'b1, 3'd1, 1'b0}; // ADDI
    vecs[3]  = '{32'h3403FFFF, 32'h0000FFFF, 5'd0, 5'd3, 5'd3, 1'b1, 3'd2, 1'b0}; // ORI
    vecs[4]  = '{32'h1000FFFF, 32'hFFFFFFFC, 5'd0, 5'd0, 5'd0, 1'b0, 3'd4, 1'b0}; // BEQ
    vecs[5]  = '{32'h00221820, 32'h00000000, 5'd1, 5'd2, 5'd3, 1'b1, 3'd0, 1'b0}; // ADD rd=3
    vecs[6]  = '{32'hFC221234, 32'h00000000, 5'd1, 5'd2, 5'd0, 1'b0, 3'd0, 1'b1}; // op 0x3F
    vecs[7]  = '{32'hAC05FFF0, 32'hFFFFFFF0, 5'd0, 5'd5, 5'd0, 1'b0, 3'd1, 1'b0}; // SW
    vecs[8]  = '{32'h8C060004, 32'h00000004, 5'd0, 5'd6, 5'd6, 1'b1, 3'd1, 1'b0}; // LW
    vecs[9]  = '{32'h14000003, 32'h0000000C, 5'd0, 5'd0, 5'd0, 1'b0, 3'd4, 1'b0}; // BNE
    vecs[10] = '{32'h30078000, 32'h00008000, 5'd0, 5'd7, 5'd7, 1'b1, 3'd2, 1'b0}; // ANDI
  end

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    reset         = 1'b1;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = 32'h0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    check_zero_outputs("reset");
    reset = 1'b0;
    tick();

    // Back-to-back decode stream with downstream always ready.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      bus.in_valid = 1'b1;
      bus.in_instr = vecs[i].instr;
      tick();
      check_rec($sformatf("dec%0d", i), vecs[i]);
      check_eq($sformatf("dec%0d.in_ready", i), 32'(bus.in_ready), 32'd1);
    end
    bus.in_valid = 1'b0;
    tick();
    check_eq("drain.valid", 32'(bus.out_valid), 32'd0);

    // Backpressure: A held, B into skid, C stalled.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = vecs[0].instr;
    tick();
    check_rec("bp.A0", vecs[0]);
    check_eq("bp.ready0", 32'(bus.in_ready), 32'd1);
    bus.in_instr = vecs[2].instr;
    tick();
    check_rec("bp.A1", vecs[0]);
    check_eq("bp.ready1", 32'(bus.in_ready), 32'd0);
    bus.in_instr = vecs[3].instr;
    tick();
    check_rec("bp.A2", vecs[0]);
    check_eq("bp.ready2", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    tick();
    check_rec("bp.B", vecs[2]);
    check_eq("bp.ready3", 32'(bus.in_ready), 32'd1);
    tick();
    check_rec("bp.C", vecs[3]);
    bus.in_valid = 1'b0;
    tick();
    check_eq("bp.empty", 32'(bus.out_valid), 32'd0);

    // Flush with both entries full and a new instruction offered.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = vecs[0].instr;
    tick();
    bus.in_instr = vecs[2].instr;
    tick();
    check_eq("fl.full_ready", 32'(bus.in_ready), 32'd0);
    bus.in_instr = vecs[8].instr;
    bus.flush    = 1'b1;
    tick();
    bus.flush = 1'b0;
    check_eq("fl.valid", 32'(bus.out_valid), 32'd0);
    check_eq("fl.ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check_eq("fl.none", 32'(bus.out_valid), 32'd0);

    // Flush while the stage could accept: the accepted word is discarded.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = vecs[3].instr;
    tick();
    bus.in_instr = vecs[10].instr;
    bus.flush    = 1'b1;
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    check_eq("fl2.valid", 32'(bus.out_valid), 32'd0);
    check_eq("fl2.ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b1;
    tick();
    check_eq("fl2.none", 32'(bus.out_valid), 32'd0);

    // Asynchronous reset between edges with both entries full.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = vecs[0].instr;
    tick();
    bus.in_instr = vecs[2].instr;
    tick();
    bus.in_valid = 1'b0;
    check_eq("ar.pre_valid", 32'(bus.out_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    check_zero_outputs("ar");
    #1 reset = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_instr  = vecs[8].instr;
    tick();
    check_rec("ar.first", vecs[8]);
    bus.in_valid = 1'b0;
    tick();
    check_eq("ar.empty", 32'(bus.out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
